// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// MULT/MULTU take one compute cycle; DIV/DIVU use a 32-step restoring divider.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic        flush,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        stall_request,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        msigned_q, msigned_d;
  logic [63:0] rq_q, rq_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        sdiv_s;
  logic [31:0] abs1_s;
  logic [31:0] abs2_s;
  logic [63:0] ext1_s;
  logic [63:0] ext2_s;
  logic [63:0] product_s;
  logic [32:0] partial_s;
  logic [32:0] diff_s;
  logic [63:0] rq_step_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Operand conditioning, product and one restoring-division step.
  always_comb begin
    sdiv_s    = (funct == FN_DIV);
    abs1_s    = (sdiv_s && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
    abs2_s    = (sdiv_s && operand_2[31]) ? (32'd0 - operand_2) : operand_2;
    ext1_s    = {{32{msigned_q & op1_q[31]}}, op1_q};
    ext2_s    = {{32{msigned_q & op2_q[31]}}, op2_q};
    product_s = ext1_s * ext2_s;
    // Shifted remainder can reach 2*divisor, so compare on 33 bits.
    partial_s = rq_q[63:31];
    diff_s    = partial_s - {1'b0, op2_q};
    if (!diff_s[32]) begin
      rq_step_s = {diff_s[31:0], rq_q[30:0], 1'b1};
    end else begin
      rq_step_s = {rq_q[62:0], 1'b0};
    end
    quot_s = qneg_q ? (32'd0 - rq_step_s[31:0])  : rq_step_s[31:0];
    rem_s  = rneg_q ? (32'd0 - rq_step_s[63:32]) : rq_step_s[63:32];
  end

  // Next-state, HI/LO update and stall/done generation.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    msigned_d     = msigned_q;
    rq_d          = rq_q;
    cnt_d         = cnt_q;
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    stall_request = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          case (funct)
            FN_MULT, FN_MULTU: begin
              op1_d         = operand_1;
              op2_d         = operand_2;
              msigned_d     = (funct == FN_MULT);
              stall_request = 1'b1;
              state_d       = S_MUL;
            end
            FN_DIV, FN_DIVU: begin
              stall_request = 1'b1;
              if (operand_2 == 32'd0) begin
                hi_d    = operand_1;
                lo_d    = 32'hFFFF_FFFF;
                state_d = S_DONE;
              end else begin
                rq_d    = {32'd0, abs1_s};
                op2_d   = abs2_s;
                qneg_d  = sdiv_s & (operand_1[31] ^ operand_2[31]);
                rneg_d  = sdiv_s & operand_1[31];
                cnt_d   = 5'd0;
                state_d = S_DIV;
              end
            end
            FN_MTHI: hi_d = operand_1;
            FN_MTLO: lo_d = operand_1;
            default: ;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        stall_request = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = product_s[63:32];
          lo_d    = product_s[31:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        stall_request = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rq_d  = rq_step_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            lo_d    = quot_s;
            hi_d    = rem_s;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      msigned_q <= 1'b0;
      rq_q      <= 64'd0;
      cnt_q     <= 5'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      msigned_q <= msigned_d;
      rq_q      <= rq_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
    end
  end

  // Move-from read port.
  always_comb begin
    case (funct)
      FN_MFHI: result = hi_q;
      FN_MFLO: result = lo_q;
      default: result = 32'd0;
    endcase
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
